// File: rtl/lc3_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3_decode_pkg
// Description : Shared types and constants for the LC3 decode stage:
//               opcode enumeration, ALU / PC-select / writeback codes,
//               control field widths and the packed E_Control layout.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package lc3_decode_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RES  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_e;

  localparam int ECTRL_W = 6;
  localparam int WCTRL_W = 2;
  localparam int MCTRL_W = 1;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_NOT = 2'b10;

  // Address base for the Execute address adder
  localparam logic [1:0] PCSEL1_NONE  = 2'b00;
  localparam logic [1:0] PCSEL1_PCREL = 2'b01;
  localparam logic [1:0] PCSEL1_BASE  = 2'b10;
  localparam logic [1:0] PCSEL1_JMP   = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_PC  = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;

  typedef struct packed {
    logic [1:0] alu_control;
    logic [1:0] pcselect1;
    logic       pcselect2;
    logic       op2select;
  } e_control_t;

endpackage
`default_nettype wire

// File: rtl/lc3_decode_ctrl_lut.sv
`default_nettype none
// ============================================================================
// Module      : lc3_decode_ctrl_lut
// Description : Purely combinational opcode decoder producing the Execute,
//               Writeback and Memory control words plus an illegal flag.
// Ports       : opcode    in  4  instruction bits [15:12]
//               ir5       in  1  instruction bit 5 (imm5 / register select)
//               e_control out 6  {alu_control, pcselect1, pcselect2, op2select}
//               w_control out 2  writeback select
//               m_control out 1  indirect memory access
//               illegal   out 1  opcode not supported
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_decode_ctrl_lut
  import lc3_decode_pkg::*;
(
  input  logic [3:0]         opcode,
  input  logic               ir5,
  output logic [ECTRL_W-1:0] e_control,
  output logic [WCTRL_W-1:0] w_control,
  output logic [MCTRL_W-1:0] m_control,
  output logic               illegal
);

  e_control_t w_e;

  always_comb begin
    w_e             = '0;
    w_e.alu_control = ALU_ADD;
    w_e.pcselect1   = PCSEL1_NONE;
    w_control       = WB_ALU;
    m_control       = '0;
    illegal         = 1'b0;
    case (opcode_e'(opcode))
      OP_ADD: w_e.op2select = ~ir5;
      OP_AND: begin
        w_e.alu_control = ALU_AND;
        w_e.op2select   = ~ir5;
      end
      OP_NOT: begin
        w_e.alu_control = ALU_NOT;
        w_e.op2select   = 1'b1;
      end
      OP_BR, OP_ST: begin
        w_e.pcselect1 = PCSEL1_PCREL;
        w_e.pcselect2 = 1'b1;
      end
      OP_LD: begin
        w_e.pcselect1 = PCSEL1_PCREL;
        w_e.pcselect2 = 1'b1;
        w_control     = WB_MEM;
      end
      OP_LDI: begin
        w_e.pcselect1 = PCSEL1_PCREL;
        w_e.pcselect2 = 1'b1;
        w_control     = WB_MEM;
        m_control     = 1'b1;
      end
      OP_STI: begin
        w_e.pcselect1 = PCSEL1_PCREL;
        w_e.pcselect2 = 1'b1;
        m_control     = 1'b1;
      end
      OP_LEA: begin
        w_e.pcselect1 = PCSEL1_PCREL;
        w_e.pcselect2 = 1'b1;
        w_control     = WB_PC;
      end
      OP_LDR: begin
        w_e.pcselect1 = PCSEL1_BASE;
        w_control     = WB_MEM;
      end
      OP_STR: w_e.pcselect1 = PCSEL1_BASE;
      OP_JMP: w_e.pcselect1 = PCSEL1_JMP;
      // JSR, RTI, reserved and TRAP: all controls stay zero
      default: illegal = 1'b1;
    endcase
  end

  assign e_control = w_e;

endmodule
`default_nettype wire

// File: rtl/lc3_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : lc3_decode_stage
// Description : LC3 decode pipeline stage. Latches the instruction and its
//               PC+1 when enable_decode is high and registers the decoded
//               Execute / Writeback / Memory controls, a one-cycle valid
//               strobe and an illegal-opcode flag.
//               Optional macro DECODE_ILLEGAL_CNT_EN adds a saturating
//               illegal-opcode counter on port illegal_cnt.
// Ports       : clk, rst (async active-low), enable_decode,
//               instr_dout[DATA_W], npc_in[DATA_W]  -> inputs
//               IR, npc_out, E_Control[6], W_Control[2], Mem_Control,
//               decode_valid, illegal_op, [illegal_cnt] -> outputs
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_decode_stage
  import lc3_decode_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ILL_CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_decode,
  input  logic [DATA_W-1:0]   instr_dout,
  input  logic [DATA_W-1:0]   npc_in,
  output logic [DATA_W-1:0]   IR,
  output logic [DATA_W-1:0]   npc_out,
  output logic [ECTRL_W-1:0]  E_Control,
  output logic [WCTRL_W-1:0]  W_Control,
  output logic [MCTRL_W-1:0]  Mem_Control,
  output logic                decode_valid,
  output logic                illegal_op
`ifdef DECODE_ILLEGAL_CNT_EN
  ,
  output logic [ILL_CNT_W-1:0] illegal_cnt
`endif
);

  logic [ECTRL_W-1:0] w_e_ctrl;
  logic [WCTRL_W-1:0] w_w_ctrl;
  logic [MCTRL_W-1:0] w_m_ctrl;
  logic               w_illegal;

  logic [DATA_W-1:0]  r_ir;
  logic [DATA_W-1:0]  r_npc;
  logic [ECTRL_W-1:0] r_e_ctrl;
  logic [WCTRL_W-1:0] r_w_ctrl;
  logic [MCTRL_W-1:0] r_m_ctrl;
  logic               r_valid;
  logic               r_illegal;

  lc3_decode_ctrl_lut u_lut (
    .opcode    (instr_dout[15:12]),
    .ir5       (instr_dout[5]),
    .e_control (w_e_ctrl),
    .w_control (w_w_ctrl),
    .m_control (w_m_ctrl),
    .illegal   (w_illegal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ir      <= '0;
      r_npc     <= '0;
      r_e_ctrl  <= '0;
      r_w_ctrl  <= '0;
      r_m_ctrl  <= '0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_valid <= enable_decode;
      if (enable_decode) begin
        r_ir      <= instr_dout;
        r_npc     <= npc_in;
        r_e_ctrl  <= w_e_ctrl;
        r_w_ctrl  <= w_w_ctrl;
        r_m_ctrl  <= w_m_ctrl;
        r_illegal <= w_illegal;
      end
    end
  end

`ifdef DECODE_ILLEGAL_CNT_EN
  localparam logic [ILL_CNT_W-1:0] c_cnt_one = {{(ILL_CNT_W-1){1'b0}}, 1'b1};

  logic [ILL_CNT_W-1:0] r_ill_cnt;

  // Saturates at all-ones so a stream of bad opcodes never wraps to zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ill_cnt <= '0;
    end else if (enable_decode && w_illegal && (r_ill_cnt != '1)) begin
      r_ill_cnt <= r_ill_cnt + c_cnt_one;
    end
  end

  assign illegal_cnt = r_ill_cnt;
`endif

  assign IR           = r_ir;
  assign npc_out      = r_npc;
  assign E_Control    = r_e_ctrl;
  assign W_Control    = r_w_ctrl;
  assign Mem_Control  = r_m_ctrl;
  assign decode_valid = r_valid;
  assign illegal_op   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_lc3_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc3_decode_stage
// Description : Self-checking bench for lc3_decode_stage. A reference model
//               pushes expected outputs into a scoreboard as each cycle is
//               driven; every test task pops and compares after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3_decode_stage;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] npc;
    logic [5:0]  e;
    logic [1:0]  w;
    logic        m;
    logic        v;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        enable_decode;
  logic [15:0] instr_dout;
  logic [15:0] npc_in;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic [0:0]  Mem_Control;
  logic        decode_valid;
  logic        illegal_op;
`ifdef DECODE_ILLEGAL_CNT_EN
  logic [7:0]  illegal_cnt;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t last;
  exp_t exp_v;
  exp_t obs;

  lc3_decode_stage #(.DATA_W(16), .ILL_CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_decode (enable_decode),
    .instr_dout    (instr_dout),
    .npc_in        (npc_in),
    .IR            (IR),
    .npc_out       (npc_out),
    .E_Control     (E_Control),
    .W_Control     (W_Control),
    .Mem_Control   (Mem_Control),
    .decode_valid  (decode_valid),
    .illegal_op    (illegal_op)
`ifdef DECODE_ILLEGAL_CNT_EN
    ,
    .illegal_cnt   (illegal_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full {E,W,M,illegal} per opcode, written out as a table
  function automatic logic [9:0] ref_ctrl(input logic [15:0] ins);
    logic b5n;
    b5n = ~ins[5];
    case (ins[15:12])
      4'b0000: ref_ctrl = {6'b000110, 2'b00, 1'b0, 1'b0};
      4'b0001: ref_ctrl = {5'b00000, b5n, 2'b00, 1'b0, 1'b0};
      4'b0010: ref_ctrl = {6'b000110, 2'b10, 1'b0, 1'b0};
      4'b0011: ref_ctrl = {6'b000110, 2'b00, 1'b0, 1'b0};
      4'b0101: ref_ctrl = {5'b01000, b5n, 2'b00, 1'b0, 1'b0};
      4'b0110: ref_ctrl = {6'b001000, 2'b10, 1'b0, 1'b0};
      4'b0111: ref_ctrl = {6'b001000, 2'b00, 1'b0, 1'b0};
      4'b1001: ref_ctrl = {6'b100001, 2'b00, 1'b0, 1'b0};
      4'b1010: ref_ctrl = {6'b000110, 2'b10, 1'b1, 1'b0};
      4'b1011: ref_ctrl = {6'b000110, 2'b00, 1'b1, 1'b0};
      4'b1100: ref_ctrl = {6'b001100, 2'b00, 1'b0, 1'b0};
      4'b1110: ref_ctrl = {6'b000110, 2'b01, 1'b0, 1'b0};
      default: ref_ctrl = {6'b000000, 2'b00, 1'b0, 1'b1};
    endcase
  endfunction

  // Drive one cycle, push the model's expectation, settle after the edge
  task automatic step(input logic en, input logic [15:0] ins, input logic [15:0] npc);
    exp_t     e;
    logic [9:0] c;
    @(negedge clk);
    enable_decode = en;
    instr_dout    = ins;
    npc_in        = npc;
    e = last;
    e.v = en;
    if (en) begin
      c     = ref_ctrl(ins);
      e.ir  = ins;
      e.npc = npc;
      e.e   = c[9:4];
      e.w   = c[3:2];
      e.m   = c[1];
      e.ill = c[0];
    end
    last = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; enable_decode = 1'b0; instr_dout = '0; npc_in = '0;
    last = '0;
    #1;
    obs = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
    checks++;
    if (obs !== exp_t'(0)) begin
      errors++; $display("FAIL reset_init: got %h expected %h", obs, exp_t'(0));
    end
    @(negedge clk); rst = 1'b1;
    step(1'b1, 16'h1042, 16'h3001);
    step(1'b1, 16'hA205, 16'h3002);
    while (sb.size() > 0) begin
      exp_v = sb.pop_front();
      obs = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
    end
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL reset_preload: got %h expected %h", obs, exp_v);
    end
    // Assert reset between edges with enable still high
    @(negedge clk);
    enable_decode = 1'b1; instr_dout = 16'h5020; npc_in = 16'h4000;
    #2 rst = 1'b0;
    #1;
    obs = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
    checks++;
    if (obs !== exp_t'(0)) begin
      errors++; $display("FAIL reset_async: got %h expected %h", obs, exp_t'(0));
    end
`ifdef DECODE_ILLEGAL_CNT_EN
    checks++;
    if (illegal_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d expected 0", illegal_cnt);
    end
`endif
    @(posedge clk); #1;
    obs = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
    checks++;
    if (obs !== exp_t'(0)) begin
      errors++; $display("FAIL reset_held: got %h expected %h", obs, exp_t'(0));
    end
    last = '0;
    @(negedge clk); rst = 1'b1; enable_decode = 1'b0;
  endtask

  task automatic test_alu_ops;
    step(1'b1, 16'h1042, 16'h3001);
    exp_v = sb.pop_front();
    obs = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL add_reg: got %h expected %h", obs, exp_v);
    end
    checks++;
    if (E_Control !== 6'b000001) begin
      errors++; $display("FAIL add_reg_ectl: got %b expected 000001", E_Control);
    end
    step(1'b1, 16'h5020, 16'h3002);
    exp_v = sb.pop_front();
    obs = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
    checks++;
    if (obs !== exp_v || E_Control !== 6'b010000) begin
      errors++; $display("FAIL and_imm: got %h expected %h", obs, exp_v);
    end
    step(1'b1, 16'h907F, 16'h3003);
    exp_v = sb.pop_front();
    obs = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL not_op: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_hold;
    step(1'b1, 16'hA205, 16'h3010);
    exp_v = sb.pop_front();
    obs = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
    checks++;
    if (obs !== exp_v || E_Control !== 6'b000110 || W_Control !== 2'b10 || Mem_Control !== 1'b1) begin
      errors++; $display("FAIL ldi_load: got %h expected %h", obs, exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h1000 + 16'(i * 16'h1111), 16'h7000 + 16'(i));
      exp_v = sb.pop_front();
      obs = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL hold_%0d: got %h expected %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_addressing;
    logic [15:0] ins [3];
    logic [5:0]  ec  [3];
    ins[0] = 16'h6042; ec[0] = 6'b001000;
    ins[1] = 16'hC1C0; ec[1] = 6'b001100;
    ins[2] = 16'hE3FF; ec[2] = 6'b000110;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, ins[i], 16'h3100 + 16'(i));
      exp_v = sb.pop_front();
      obs = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
      checks++;
      if (obs !== exp_v || E_Control !== ec[i]) begin
        errors++; $display("FAIL addr_%h: got %h expected %h", ins[i], obs, exp_v);
      end
    end
    checks++;
    if (W_Control !== 2'b01) begin
      errors++; $display("FAIL lea_wctl: got %b expected 01", W_Control);
    end
  endtask

  task automatic test_illegal;
    step(1'b1, 16'hD000, 16'h3200);
    step(1'b1, 16'hF025, 16'h3201);
    for (int i = 0; i < 2; i++) begin
      exp_v = sb.pop_front();
      if (i == 1) begin
        obs = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
        checks++;
        if (obs !== exp_v || illegal_op !== 1'b1) begin
          errors++; $display("FAIL illegal_b2b: got %h expected %h", obs, exp_v);
        end
      end
    end
`ifdef DECODE_ILLEGAL_CNT_EN
    checks++;
    if (illegal_cnt !== 8'd2) begin
      errors++; $display("FAIL illegal_cnt2: got %0d expected 2", illegal_cnt);
    end
`endif
    for (int i = 0; i < 298; i++) begin
      step(1'b1, (i % 2 == 0) ? 16'h4ABC : 16'h8001, 16'(i));
      exp_v = sb.pop_front();
    end
    obs = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL illegal_run: got %h expected %h", obs, exp_v);
    end
`ifdef DECODE_ILLEGAL_CNT_EN
    checks++;
    if (illegal_cnt !== 8'd255) begin
      errors++; $display("FAIL illegal_sat: got %0d expected 255", illegal_cnt);
    end
`endif
    step(1'b1, 16'h1261, 16'h3300);
    exp_v = sb.pop_front();
    obs = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
    checks++;
    if (obs !== exp_v || illegal_op !== 1'b0) begin
      errors++; $display("FAIL illegal_clear: got %h expected %h", obs, exp_v);
    end
`ifdef DECODE_ILLEGAL_CNT_EN
    checks++;
    if (illegal_cnt !== 8'd255) begin
      errors++; $display("FAIL illegal_cnt_keep: got %0d expected 255", illegal_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back;
    // Every opcode once with both ir5 values, then random enables
    for (int i = 0; i < 32; i++) begin
      step(1'b1, {4'(i >> 1), 6'h15, 1'(i), 5'h0A}, 16'(16'h5000 + i));
      exp_v = sb.pop_front();
      obs = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL b2b_%0d: got %h expected %h", i, obs, exp_v);
      end
    end
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      exp_v = sb.pop_front();
      obs = {IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op};
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL rand_%0d: got %h expected %h", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset;
    test_alu_ops;
    test_hold;
    test_addressing;
    test_illegal;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lc3_decode_stage.md
Name: lc3_decode_stage

Overview:
- Receiving end of the decode_in interface.
- Samples instr_dout, npc_in and enable_decode on each clock and decodes the LC3 instruction into registered pipeline outputs for Execute, Writeback and Memory.
- Outputs: IR, npc_out, E_Control, W_Control, Mem_Control, plus a valid strobe and an illegal-opcode flag.
- Sits between the Fetch stage, which drives decode_in, and the Execute stage.

Parameters:
- DATA_W, 16, width of the instruction and PC buses.
- ILL_CNT_W, 8, width of the illegal-opcode counter (used only with the optional feature).

Ports:
- clk  in  1  Single clock; all logic on posedge.
- rst  in  1  Asynchronous, active-low reset.
- enable_decode  in  1  Load enable from Fetch/controller.
- instr_dout  in  DATA_W  Instruction word from instruction memory.
- npc_in  in  DATA_W  PC+1 of that instruction.
- IR  out  DATA_W  Latched instruction.
- npc_out  out  DATA_W  Latched npc_in.
- E_Control  out  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- W_Control  out  2  Writeback select.
- Mem_Control  out  1  Indirect memory access (LDI/STI).
- decode_valid  out  1  High the cycle after a load with enable_decode=1.
- illegal_op  out  1  Latched opcode is unsupported.
- illegal_cnt  out  ILL_CNT_W  Present only with DECODE_ILLEGAL_CNT_EN.

Behaviour:
- Reset (rst=0, asynchronous): every output and internal register goes to 0 immediately, including mid-operation. The first load happens on the first posedge after rst rises.
- Load: on posedge clk with enable_decode=1:
  - IR<=instr_dout; npc_out<=npc_in.
  - All control outputs are updated from instr_dout[15:12].
  - decode_valid<=1.
  - Latency is 1 cycle.
- Hold: on posedge clk with enable_decode=0, IR, npc_out and all controls hold their value; decode_valid<=0.
- alu_control: ADD(0001)=00, AND(0101)=01, NOT(1001)=10; all other opcodes 00.
- pcselect1:
  - BR(0000), LD(0010), LDI(1010), LEA(1110), ST(0011), STI(1011) = 01.
  - LDR(0110), STR(0111) = 10.
  - JMP(1100) = 11.
  - ALU ops 00.
- pcselect2: 1 for BR/LD/LDI/LEA/ST/STI; 0 otherwise.
- op2select:
  - ADD/AND: 1 when instr_dout[5]=0 (register operand); 0 when instr_dout[5]=1 (imm5).
  - NOT: 1.
  - Others: 0.
- W_Control: ADD/AND/NOT=00; LEA=01; LD/LDR/LDI=10; all others 00.
- Mem_Control: 1 for LDI/STI; otherwise 0.
- Illegal opcodes are 0100, 1000, 1101 and 1111:
  - E_Control, W_Control and Mem_Control load 0.
  - illegal_op<=1.
  - IR and npc_out still load.
  - Any legal load clears illegal_op.
- Back-to-back enables: each cycle loads a new instruction; there are no bubbles.
- Simultaneous reset and enable: reset wins.

Optional Feature:
- Macro: DECODE_ILLEGAL_CNT_EN.
- When defined:
  - illegal_cnt port exists.
  - It increments by 1 on each load of an illegal opcode, saturating at all-ones with no wrap.
  - It clears on reset.
- When undefined: the port and counter are absent, and illegal_op behaviour is unchanged.

Decomposition:
- lc3_decode_pkg holds:
  - Opcode enum (4-bit).
  - ALU_ADD/ALU_AND/ALU_NOT codes.
  - PCSEL1_* and WB_ALU/WB_PC/WB_MEM constants.
  - Control field widths.
  - Packed struct typedef for E_Control.
- Sub-module lc3_decode_ctrl_lut: combinational opcode+IR[5] to {E_Control, W_Control, Mem_Control, illegal}.
- The top level holds the registers, enable gating, valid strobe and optional counter.

Test Plan:
- Reset: rst=0 mid-stream with enable_decode=1 → all outputs 0 immediately, without waiting for a clock edge; first load occurs the cycle after rst=1.
- ADD register form: enable=1, instr_dout=16'h1042, npc_in=16'h3001 → next cycle:
  - IR=1042, npc_out=3001.
  - E_Control=6'b000001, W_Control=00, Mem_Control=0, decode_valid=1.
- AND immediate form: instr_dout=16'h5020 → E_Control=6'b010000, W_Control=00.
- Hold: a load of LDI 16'hA205 gives E_Control=6'b000110, W_Control=10, Mem_Control=1. Then enable=0 for 3 cycles with changing instr_dout → all outputs hold; decode_valid=0 after the first hold edge.
- Addressing ops:
  - LDR 16'h6042 → E_Control=6'b001000, W_Control=10.
  - JMP 16'hC1C0 → E_Control=6'b001100.
  - LEA 16'hE3FF → E_Control=6'b000110, W_Control=01.
- Illegal opcodes: 16'hD000 then 16'hF025 back-to-back → illegal_op=1 and controls 0 for both loads.
  - With DECODE_ILLEGAL_CNT_EN, illegal_cnt=2.
  - 300 illegal loads saturate illegal_cnt at 255.
  - A following ADD clears illegal_op.
